tc_sram_mport: RTL

TC_SRAM_MPORT -- requirements
Module: tc_sram_mport

---
 rtl/tc_sram_mport.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tc_sram_mport.sv
// Multi-port SRAM model with byte-lane writes, read-first collisions and lowest-port-wins write merging.
// Latency: reads return Latency cycles after issue; writes are visible to reads on the following cycle.
// Backpressure: none; every request on every port is accepted each cycle.
//
// Ports:
//   clk_i, rst_ni            clock and synchronous active-low reset
//   req_i, we_i              per-port request and write enable (we_i qualified by req_i)
//   addr_i, wdata_i, be_i    per-port word address, write data and byte-lane enables
//   rvalid_o, rdata_o        per-port read response; rdata_o holds its last value between responses
module tc_sram_mport #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned Latency   = 1,
    parameter bit          ResetMem  = 1'b0,
    localparam int unsigned AddrWidth = $clog2(NumWords),
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

    logic [DataWidth-1:0] mem [NumWords];

    logic [NumPorts-1:0]                rd_en;
    logic [NumPorts-1:0]                wr_en;
    logic [NumPorts-1:0]                in_range;
    logic [NumPorts-1:0][DataWidth-1:0] bit_en;
    logic [NumPorts-1:0][DataWidth-1:0] wr_word;

    // Read pipeline: stage 0 captures the array at the issue edge, the last
    // stage drives the outputs. A data stage only loads when the stage before
    // it is valid, so the last stage keeps the most recent response.
    logic [NumPorts-1:0]                vld_q [Latency];
    logic [NumPorts-1:0][DataWidth-1:0] dat_q [Latency];

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            // Widened compare so a power-of-two NumWords does not wrap to 0.
            in_range[p] = ({1'b0, addr_i[p]} < (AddrWidth + 1)'(NumWords));
            rd_en[p]    = req_i[p] & ~we_i[p];
            wr_en[p]    = req_i[p] & we_i[p] & in_range[p];
            // The top lane absorbs any leftover bits when DataWidth is not a
            // multiple of ByteWidth.
            for (int i = 0; i < DataWidth; i++) begin
                bit_en[p][i] = be_i[p][i / ByteWidth];
            end
        end
    end

    // Every writing port computes the full merged word for its address, so
    // colliding ports all store the same value. Ports are folded in from the
    // highest index down, leaving the lowest-indexed port on top per lane.
    always_comb begin
        logic [DataWidth-1:0] w;
        wr_word = '0;
        for (int p = 0; p < NumPorts; p++) begin
            w = mem[addr_i[p]];
            for (int q = NumPorts - 1; q >= 0; q--) begin
                if (wr_en[q] && (addr_i[q] == addr_i[p])) begin
                    w = (w & ~bit_en[q]) | (wdata_i[q] & bit_en[q]);
                end
            end
            wr_word[p] = w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            if (ResetMem) begin
                for (int w = 0; w < NumWords; w++) begin
                    mem[w] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (wr_en[p]) begin
                    mem[addr_i[p]] <= wr_word[p];
                end
            end
        end
    end

    // The array read here sees pre-write contents, which gives read-first
    // behaviour for same-cycle read/write collisions.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < Latency; s++) begin
                vld_q[s] <= '0;
                dat_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            for (int p = 0; p < NumPorts; p++) begin
                if (rd_en[p]) begin
                    dat_q[0][p] <= in_range[p] ? mem[addr_i[p]] : '0;
                end
            end
            for (int s = 1; s < Latency; s++) begin
                vld_q[s] <= vld_q[s-1];
                for (int p = 0; p < NumPorts; p++) begin
                    if (vld_q[s-1][p]) begin
                        dat_q[s][p] <= dat_q[s-1][p];
                    end
                end
            end
        end
    end

    assign rvalid_o = vld_q[Latency-1];
    assign rdata_o  = dat_q[Latency-1];

endmodule
